ifetch_prefetch: RTL and testbench

//  Parametrised instruction-fetch unit with prefetch queue; owns the fetch PC and replaces pc_reg + ifetch.

---
 rtl/ifetch_prefetch_pkg.sv | 16 +
 rtl/ifetch_prefetch_sync_fifo.sv | 68 ++++++
 rtl/ifetch_prefetch.sv | 116 +++++++++++
 tb/tb_ifetch_prefetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_pkg.sv
// rtl/ifetch_prefetch_pkg.sv - shared constants and width helper for the fetch unit
// Purpose: default address width, the NOP presented on an empty queue, the PC step
//          per instruction, and the occupancy-counter width helper.
// Ports:   none (package).
package ifetch_prefetch_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam int          PC_STEP      = 4;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_prefetch_sync_fifo.sv
// rtl/ifetch_prefetch_sync_fifo.sv - synchronous FIFO holding prefetched {pc, inst} entries
// Purpose: DEPTH-entry queue with same-cycle push/pop (also when full) and a
//          clear that wins over both.
// Ports:   clk, rst_n        clock, asynchronous active-low reset
//          push_i/push_data_i write an entry
//          pop_i              retire the head entry
//          clear_i            empty the queue
//          head_data_o        head entry (undefined contents when empty)
//          empty_o, count_o   occupancy status
module ifetch_prefetch_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign empty_o     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count_o     = r_wr_ptr - r_rd_ptr;
    assign head_data_o = r_mem[r_rd_ptr[AW-1:0]];

    assign w_pop_ok  = pop_i && !empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = push_i && (!w_full || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !clear_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// rtl/ifetch_prefetch.sv - instruction fetch unit with prefetch queue and redirect flush
// Purpose: owns the fetch PC, issues in-order requests to a variable-latency
//          instruction memory, buffers up to DEPTH responses and presents the
//          head {inst, addr} to if_id. A jump clears the queue and discards
//          every response still in flight.
// Ports:   clk, rst_n                         clock, asynchronous active-low reset
//          jump_en_i, jump_addr_i             redirect from ctrl
//          hold_flag_i                        downstream stall, inhibits pop
//          mem_req_valid_o/addr_o/ready_i     fetch request handshake
//          mem_rsp_valid_i, mem_rsp_inst_i    in-order instruction return
//          inst_valid_o, inst_o, inst_addr_o  queue head to if_id
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            hold_flag_i,
    output logic            mem_req_valid_o,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_req_ready_i,
    input  logic            mem_rsp_valid_i,
    input  logic [31:0]     mem_rsp_inst_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_addr_o
);

    localparam int              CW       = cnt_width(DEPTH);
    localparam logic [CW:0]     LP_DEPTH = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] LP_STEP  = XLEN'(PC_STEP);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [CW-1:0]      r_outst;
    logic [CW-1:0]      r_drop;

    logic [CW-1:0]      w_count;
    logic               w_empty;
    logic [CW:0]        w_inflight;
    logic               w_req_fire;
    logic               w_rsp;
    logic               w_discard;
    logic               w_push;
    logic               w_pop;
    logic [XLEN+31:0]   w_head;

    // Queue entries plus outstanding requests never exceed DEPTH, so every
    // response already has a reserved slot and the memory needs no backpressure.
    assign w_inflight      = {1'b0, w_count} + {1'b0, r_outst};
    assign mem_req_valid_o = rst_n && !jump_en_i && (w_inflight < LP_DEPTH);
    assign mem_req_addr_o  = r_fetch_pc;
    assign w_req_fire      = mem_req_valid_o && mem_req_ready_i;

    // A response with nothing outstanding is ignored.
    assign w_rsp     = mem_rsp_valid_i && (r_outst != '0);
    assign w_discard = (r_drop != '0) || jump_en_i;
    assign w_push    = w_rsp && !w_discard;
    assign w_pop     = !w_empty && !hold_flag_i && !jump_en_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else if (jump_en_i) begin
            // Everything still outstanding after this cycle belongs to the old
            // path; that already covers any pending drop since drop <= outst.
            r_fetch_pc <= jump_addr_i;
            r_rsp_pc   <= jump_addr_i;
            r_outst    <= r_outst - CW'(w_rsp);
            r_drop     <= r_outst - CW'(w_rsp);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + LP_STEP;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + LP_STEP;
            end
            r_outst <= r_outst + CW'(w_req_fire) - CW'(w_rsp);
            if (w_rsp && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
        end
    end

    ifetch_prefetch_sync_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i ({r_rsp_pc, mem_rsp_inst_i}),
        .pop_i       (w_pop),
        .clear_i     (jump_en_i),
        .head_data_o (w_head),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    assign inst_valid_o = !w_empty;
    assign inst_o       = w_empty ? INST_NOP : w_head[31:0];
    assign inst_addr_o  = w_empty ? '0 : w_head[XLEN+31:32];

    a_rsp_has_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) mem_rsp_valid_i |-> (r_outst != '0)
    );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb/tb_ifetch_prefetch.sv - directed self-checking bench for ifetch_prefetch
module tb_ifetch_prefetch;

    logic        clk;
    logic        rst_n;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_inst_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc   = 0;
    int    lat   = 1;
    int    n_req = 0;

    ifetch_prefetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jump_en_i       (jump_en_i),
        .jump_addr_i     (jump_addr_i),
        .hold_flag_i     (hold_flag_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_inst_i  (mem_rsp_inst_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency in-order memory: a request accepted at edge k is returned
    // during the cycle before edge k+lat; the instruction word is ~addr.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            n_req = 0;
            #1;
            mem_rsp_valid_i = 1'b0;
            mem_rsp_inst_i  = '0;
        end else begin
            if (mem_req_valid_o && mem_req_ready_i) begin
                mq.push_back('{addr: mem_req_addr_o, due: cyc + lat - 1});
                n_req++;
            end
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_inst_i  = ~mq[0].addr;
                void'(mq.pop_front());
            end else begin
                mem_rsp_valid_i = 1'b0;
                mem_rsp_inst_i  = '0;
            end
        end
    end

    task automatic do_reset(input logic hold);
        rst_n       = 1'b0;
        hold_flag_i = hold;
        jump_en_i   = 1'b0;
        jump_addr_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        hold_flag_i     = 1'b0;
        jump_en_i       = 1'b0;
        jump_addr_i     = '0;
        mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_inst_i  = '0;
        repeat (2) @(negedge clk);
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid_o); end
        total++; if (inst_o !== 32'h0000_0013) begin bad++; $display("FAIL rst_inst got=%h want=00000013", inst_o); end
        total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", inst_addr_o); end
        total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req_valid_o); end
    endtask

    task automatic test_stream;
        lat = 1;
        do_reset(1'b0);
        @(negedge clk);
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL stream_early got=%b want=0", inst_valid_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * k)) begin
                bad++; $display("FAIL stream_addr%0d got=%b/%h want=1/%h", k, inst_valid_o, inst_addr_o, 32'(4 * k));
            end
            total++;
            if (inst_o !== ~32'(4 * k)) begin
                bad++; $display("FAIL stream_inst%0d got=%h want=%h", k, inst_o, ~32'(4 * k));
            end
        end
    endtask

    task automatic test_hold_full;
        lat = 1;
        do_reset(1'b1);
        repeat (10) @(negedge clk);
        total++; if (n_req !== 4) begin bad++; $display("FAIL hold_nreq got=%0d want=4", n_req); end
        total++; if (dut.w_count !== 3'd4) begin bad++; $display("FAIL hold_count got=%0d want=4", dut.w_count); end
        total++; if (dut.r_outst !== 3'd0) begin bad++; $display("FAIL hold_outst got=%0d want=0", dut.r_outst); end
        total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL hold_req got=%b want=0", mem_req_valid_o); end
        hold_flag_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * k)) begin
                bad++; $display("FAIL drain_addr%0d got=%b/%h want=1/%h", k, inst_valid_o, inst_addr_o, 32'(4 * k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump_latency;
        int          first;
        int          stale;
        logic [31:0] first_addr;
        lat = 3;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        total++; if (dut.r_outst !== 3'd3) begin bad++; $display("FAIL jmp_outst got=%0d want=3", dut.r_outst); end
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h100;
        @(negedge clk);
        jump_en_i = 1'b0;
        first = -1; stale = 0; first_addr = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (inst_valid_o) begin
                if (first < 0) begin first = i; first_addr = inst_addr_o; end
                if (inst_addr_o < 32'h100) stale++;
            end
        end
        total++; if (first !== 4) begin bad++; $display("FAIL jmp_first_cycle got=%0d want=4", first); end
        total++; if (first_addr !== 32'h100) begin bad++; $display("FAIL jmp_first_addr got=%h want=00000100", first_addr); end
        total++; if (stale !== 0) begin bad++; $display("FAIL jmp_stale got=%0d want=0", stale); end
        total++; if (dut.r_drop !== 3'd0) begin bad++; $display("FAIL jmp_drop got=%0d want=0", dut.r_drop); end
    endtask

    task automatic test_back_to_back;
        int          first;
        int          stale;
        logic [31:0] first_addr;
        lat = 3;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h180;
        @(negedge clk);
        jump_addr_i = 32'h200;
        @(negedge clk);
        jump_en_i = 1'b0;
        first = -1; stale = 0; first_addr = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (inst_valid_o) begin
                if (first < 0) begin first = i; first_addr = inst_addr_o; end
                if (inst_addr_o < 32'h200) stale++;
            end
        end
        total++; if (first !== 4) begin bad++; $display("FAIL b2b_first_cycle got=%0d want=4", first); end
        total++; if (first_addr !== 32'h200) begin bad++; $display("FAIL b2b_first_addr got=%h want=00000200", first_addr); end
        total++; if (stale !== 0) begin bad++; $display("FAIL b2b_stale got=%0d want=0", stale); end
        total++; if (dut.r_drop !== 3'd0) begin bad++; $display("FAIL b2b_drop got=%0d want=0", dut.r_drop); end
    endtask

    task automatic test_wrap;
        int          first;
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        lat = 1;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        jump_en_i   = 1'b1;
        jump_addr_i = 32'hFFFF_FFF8;
        @(negedge clk);
        jump_en_i = 1'b0;
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            @(negedge clk);
            if (inst_valid_o) first = i;
        end
        total++; if (first !== 2) begin bad++; $display("FAIL wrap_first_cycle got=%0d want=2", first); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (inst_valid_o !== 1'b1 || inst_addr_o !== exp_addr[k]) begin
                bad++; $display("FAIL wrap_addr%0d got=%b/%h want=1/%h", k, inst_valid_o, inst_addr_o, exp_addr[k]);
            end
            total++;
            if (inst_o !== ~exp_addr[k]) begin
                bad++; $display("FAIL wrap_inst%0d got=%h want=%h", k, inst_o, ~exp_addr[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        lat = 1;
        do_reset(1'b1);
        repeat (8) @(negedge clk);
        total++; if (inst_valid_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            bad++; $display("FAIL mid_full got=%b/%b want=1/0", inst_valid_o, mem_req_valid_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", inst_valid_o); end
        total++; if (inst_o !== 32'h0000_0013) begin bad++; $display("FAIL mid_inst got=%h want=00000013", inst_o); end
        total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL mid_addr got=%h want=0", inst_addr_o); end
        repeat (2) @(negedge clk);
        hold_flag_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL mid_restart_early got=%b want=0", inst_valid_o); end
        @(negedge clk);
        total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin
            bad++; $display("FAIL mid_restart got=%b/%h want=1/00000000", inst_valid_o, inst_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_full();
        test_jump_latency();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
